// File: rtl/audio_adc_receiver.sv
// Codec ADC capture: I2S / left-justified stereo deserializer.
// Codec clocks are oversampled on Clk; pairs leave via valid/ack.
module audio_adc_receiver #(
  parameter int DATA_W    = 16,
  parameter int I2S_DELAY = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              enable,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  input  logic              sample_ack,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + I2S_DELAY + 1);

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    SHIFT,
    SLOT_DONE,
    PUBLISH
  } state_t;

  localparam state_t START = (I2S_DELAY == 0) ? SHIFT : DELAY;

  logic [2:0]        bclk_q;
  logic [2:0]        lrck_q;
  logic [1:0]        dat_q;
  logic              bclk_rise;
  logic              lr_edge;
  logic              lr_fall;
  logic              dat_s;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] left_hold;
  logic [DATA_W-1:0] shift_next;
  logic              slot_r;
  logic              wait_f;

  // Two-flop synchronizers plus a history flop for edge detect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bclk_q <= '0;
      lrck_q <= '0;
      dat_q  <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], AUD_BCLK};
      lrck_q <= {lrck_q[1:0], AUD_ADCLRCK};
      dat_q  <= {dat_q[0], AUD_ADCDAT};
    end
  end

  assign bclk_rise  = bclk_q[1] & ~bclk_q[2];
  assign lr_edge    = lrck_q[1] ^ lrck_q[2];
  assign lr_fall    = lr_edge & ~lrck_q[1];
  assign dat_s      = dat_q[1];
  assign shift_next = {sr[DATA_W-2:0], dat_s};
  assign busy       = (state != IDLE);

  // Frame FSM: slot alignment, capture, publish and handshake
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      left_hold    <= '0;
      slot_r       <= 1'b0;
      wait_f       <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (sample_valid && sample_ack)
        sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (enable && lr_fall) begin
            slot_r <= 1'b0;
            wait_f <= 1'b0;
            state  <= START;
          end
        end
        DELAY, SHIFT: begin
          if (!enable && !slot_r) begin
            state <= IDLE;
          end else if (lr_edge) begin
            cnt    <= '0;
            slot_r <= 1'b0;
            wait_f <= 1'b0;
            state  <= (enable && lr_fall) ? START : IDLE;
          end else if (bclk_rise) begin
            if (state == DELAY) begin
              if (cnt == CW'(I2S_DELAY - 1)) begin
                cnt   <= '0;
                state <= SHIFT;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              sr <= shift_next;
              if (cnt == CW'(DATA_W - 1)) begin
                cnt   <= '0;
                state <= SLOT_DONE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        SLOT_DONE: begin
          if (!slot_r)
            left_hold <= sr;
          if (!enable && (wait_f || !slot_r)) begin
            state <= IDLE;
          end else if (slot_r && !wait_f) begin
            state <= PUBLISH;
          end else if (lr_edge) begin
            cnt <= '0;
            if (wait_f) begin
              if (lr_fall) begin
                slot_r <= 1'b0;
                wait_f <= 1'b0;
                state  <= START;
              end
            end else begin
              slot_r <= lrck_q[1];
              state  <= START;
            end
          end
        end
        PUBLISH: begin
          left_data    <= left_hold;
          right_data   <= sr;
          sample_valid <= 1'b1;
          if (sample_valid && !sample_ack)
            overrun <= 1'b1;
          wait_f <= 1'b1;
          state  <= SLOT_DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Scoreboard bench for audio_adc_receiver (I2S and left-justified).
// Codec lines are driven per instance; monitor pops on each publish.
module tb_audio_adc_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en   [2];
  logic        bclk [2];
  logic        lrck [2];
  logic        dat  [2];
  logic        ack  [2];
  logic [15:0] ld   [2];
  logic [15:0] rd   [2];
  logic        v    [2];
  logic        ov   [2];
  logic        bz   [2];

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int          checks = 0;
  int          errors = 0;
  int          lat;
  int          lat_pub;

  always #10 clk = ~clk;

  audio_adc_receiver #(.DATA_W(16), .I2S_DELAY(1)) dut0 (
    .Clk(clk), .Reset(rst), .enable(en[0]),
    .AUD_BCLK(bclk[0]), .AUD_ADCLRCK(lrck[0]), .AUD_ADCDAT(dat[0]),
    .left_data(ld[0]), .right_data(rd[0]),
    .sample_valid(v[0]), .sample_ack(ack[0]),
    .overrun(ov[0]), .busy(bz[0])
  );

  audio_adc_receiver #(.DATA_W(16), .I2S_DELAY(0)) dut1 (
    .Clk(clk), .Reset(rst), .enable(en[1]),
    .AUD_BCLK(bclk[1]), .AUD_ADCLRCK(lrck[1]), .AUD_ADCDAT(dat[1]),
    .left_data(ld[1]), .right_data(rd[1]),
    .sample_valid(v[1]), .sample_ack(ack[1]),
    .overrun(ov[1]), .busy(bz[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One BCLK period (16 Clk): low half with data, then rising edge.
  task automatic period(input int s, input logic b, input int ack_at);
    logic v0;
    bclk[s] = 1'b0;
    dat[s]  = b;
    tick(8);
    v0      = v[s];
    bclk[s] = 1'b1;
    lat     = -1;
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      if (c == ack_at) ack[s] = 1'b1;
      if (ack_at > 0 && c == ack_at + 1) ack[s] = 1'b0;
      if (lat < 0 && !v0 && v[s]) lat = c;
    end
  endtask

  task automatic slot(input int s, input logic lr, input logic [15:0] w,
                      input int d, input int n, input int ack_bit);
    int   j;
    logic b;
    lrck[s] = lr;
    for (int k = 0; k < n; k++) begin
      j = k - d;
      b = (j >= 0 && j < 16) ? w[15-j] : 1'b0;
      period(s, b, (k == ack_bit) ? 4 : 0);
      if (k == d + 15) lat_pub = lat;
    end
  endtask

  task automatic frame(input int s, input logic [15:0] l,
                       input logic [15:0] r, input int d,
                       input int ack_bit);
    if (s == 0) q0.push_back({l, r});
    else        q1.push_back({l, r});
    slot(s, 1'b0, l, d, 32, -1);
    slot(s, 1'b1, r, d, 32, ack_bit);
  endtask

  task automatic pulse_ack(input int s);
    ack[s] = 1'b1;
    tick(1);
    ack[s] = 1'b0;
  endtask

  // Monitor: a publish is valid rising or data changing while valid
  initial begin
    logic        pv [2];
    logic [31:0] pd [2];
    logic [31:0] exp;
    logic [31:0] got;
    for (int s = 0; s < 2; s++) begin
      pv[s] = 1'b0;
      pd[s] = '0;
    end
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        got = {ld[s], rd[s]};
        if (rst) begin
          pv[s] = 1'b0;
          pd[s] = '0;
        end else begin
          if (v[s] && (!pv[s] || got != pd[s])) begin
            if ((s == 0 && q0.size() == 0) ||
                (s == 1 && q1.size() == 0)) begin
              checks++;
              errors++;
              $display("FAIL pub%0d_unexpected: got %h expected none",
                       s, got);
            end else begin
              exp = (s == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("pub%0d_pair", s), got, exp);
            end
          end
          pv[s] = v[s];
          pd[s] = got;
        end
      end
    end
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      en[s]   = 1'b0;
      bclk[s] = 1'b0;
      lrck[s] = 1'b1;
      dat[s]  = 1'b0;
      ack[s]  = 1'b0;
    end
    lat_pub = -1;
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d_valid", s), 32'(v[s]), 32'd0);
      chk($sformatf("rst%0d_overrun", s), 32'(ov[s]), 32'd0);
      chk($sformatf("rst%0d_busy", s), 32'(bz[s]), 32'd0);
      chk($sformatf("rst%0d_data", s), {ld[s], rd[s]}, 32'd0);
    end
    en[0] = 1'b1;
    tick(4);

    frame(0, 16'hA5C3, 16'h0F81, 1, -1);
    chk("a_latency_ok", 32'(lat_pub > 0 && lat_pub <= 6), 32'd1);
    chk("a_valid", 32'(v[0]), 32'd1);

    frame(0, 16'h3C5A, 16'hC3A5, 1, 16);
    chk("b_valid_held", 32'(v[0]), 32'd1);
    chk("b_overrun_clear", 32'(ov[0]), 32'd0);
    pulse_ack(0);
    chk("b_ack_clears", 32'(v[0]), 32'd0);

    frame(0, 16'h1111, 16'h2222, 1, -1);
    frame(0, 16'h4444, 16'h8888, 1, -1);
    chk("cd_overrun", 32'(ov[0]), 32'd1);
    chk("cd_valid", 32'(v[0]), 32'd1);
    pulse_ack(0);
    chk("cd_ack_clears", 32'(v[0]), 32'd0);
    chk("cd_overrun_sticky", 32'(ov[0]), 32'd1);

    slot(0, 1'b0, 16'hDEAD, 1, 11, -1);
    slot(0, 1'b1, 16'hBEEF, 1, 32, -1);
    frame(0, 16'h1234, 16'h8001, 1, -1);

    slot(0, 1'b0, 16'h7777, 1, 8, -1);
    chk("mid_busy", 32'(bz[0]), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(v[0]), 32'd0);
    chk("mid_rst_overrun", 32'(ov[0]), 32'd0);
    chk("mid_rst_busy", 32'(bz[0]), 32'd0);
    chk("mid_rst_data", {ld[0], rd[0]}, 32'd0);
    tick(1);
    rst = 1'b0;
    for (int k = 8; k < 32; k++) period(0, 1'b1, 0);
    slot(0, 1'b1, 16'h5A5A, 1, 32, -1);
    frame(0, 16'h6E21, 16'h9B07, 1, -1);
    chk("e_overrun", 32'(ov[0]), 32'd0);

    en[1] = 1'b1;
    tick(4);
    frame(1, 16'hFFFF, 16'h0000, 0, -1);
    chk("lj_valid", 32'(v[1]), 32'd1);
    slot(1, 1'b0, 16'h5555, 0, 5, -1);
    chk("lj_busy_before", 32'(bz[1]), 32'd1);
    en[1] = 1'b0;
    tick(1);
    chk("lj_busy_dropped", 32'(bz[1]), 32'd0);
    for (int k = 5; k < 32; k++) period(1, 1'b0, 0);
    slot(1, 1'b1, 16'hAAAA, 0, 32, -1);
    chk("lj_valid_kept", 32'(v[1]), 32'd1);
    chk("lj_data_kept", {ld[1], rd[1]}, 32'hFFFF0000);

    tick(4);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
